fetch_buffer: RTL and testbench

// - Instruction fetch front end. Owns the fetch PC and runs a req/ack handshake to instruction memory.
// - Buffers fetched {pc, instr} pairs in a small FIFO and hands them to the fetch/decode pipe register with valid/ready.
// - Flushes and restarts on a branch redirect from the memory-stage branch control.

---
 rtl/fetch_buffer_pkg.sv | 19 +
 rtl/fetch_buffer_if.sv | 24 ++
 rtl/fetch_buffer_fifo.sv | 56 +++++
 rtl/fetch_buffer.sv | 106 ++++++++++
 tb/tb_fetch_buffer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The package is named riscv_pkg because the rest of the core imports that name.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Instruction-memory request/ack channel and fetch-to-decode valid/ready channel.
interface fetch_buffer_if;
    import riscv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_instr;

    modport master (
        output imem_req, imem_addr, dec_valid, dec_pc, dec_instr,
        input  imem_ack, imem_rdata, dec_ready
    );

    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_pc, dec_instr,
        output imem_ack, imem_rdata, dec_ready
    );

endinterface

// File: rtl/fetch_buffer_fifo.sv
// Synchronous FIFO of {pc, instr} fetch entries with flush; head is the oldest entry.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Entry storage carries no reset; only pointers and count are control state.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch front end: owns the fetch PC, runs the imem req/ack handshake and buffers results for decode.
// Optional same-cycle ack-to-decode bypass is enabled by defining FETCH_BYPASS_EN.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter  int              DEPTH    = 4,
    parameter  logic [XLEN-1:0] RESET_PC = '0,
    localparam int              CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    fetch_buffer_if.master    bus,
    output logic [CNT_W-1:0]  occupancy
);

    localparam logic [1:0]     ST_IDLE = IDLE;
    localparam logic [1:0]     ST_BUSY = BUSY;
    localparam logic [1:0]     ST_DROP = DROP;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [1:0]      state;
    logic [XLEN-1:0] fetch_pc;
    logic            fifo_empty;
    logic            bypass_hit;
    logic            push;
    logic            pop;
    logic            launch;
    logic [CNT_W:0]  cnt_next;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign fifo_empty = (occupancy == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = fifo_empty && (state == ST_BUSY) && bus.imem_ack && !redirect_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed entry consumed by decode this cycle never occupies a FIFO slot.
    assign push = (state == ST_BUSY) && bus.imem_ack && !redirect_valid
                  && !(bypass_hit && bus.dec_ready);
    assign pop  = !fifo_empty && bus.dec_ready && !redirect_valid;

    assign cnt_next = {1'b0, occupancy} + (CNT_W + 1)'(push) - (CNT_W + 1)'(pop);

    // A launch reserves the slot its response will land in, so it needs cnt_next < DEPTH.
    assign launch = !redirect_valid && (cnt_next < DEPTH_C)
                    && ((state == ST_IDLE) || ((state == ST_BUSY) && bus.imem_ack));

    assign push_entry.pc    = bus.imem_addr;
    assign push_entry.instr = bus.imem_rdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= RESET_PC;
            fetch_pc      <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~XLEN'(3);
            // An unanswered request cannot be aborted; wait out its ack in DROP.
            if ((state != ST_IDLE) && !bus.imem_ack) begin
                state <= ST_DROP;
            end else begin
                state        <= ST_IDLE;
                bus.imem_req <= 1'b0;
            end
        end else if (launch) begin
            state         <= ST_BUSY;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= fetch_pc;
            fetch_pc      <= fetch_pc + XLEN'(4);
        end else if ((state != ST_IDLE) && bus.imem_ack) begin
            state        <= ST_IDLE;
            bus.imem_req <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (occupancy),
        .head       (head)
    );

    always_comb begin
        bus.dec_valid = !fifo_empty;
        bus.dec_pc    = fifo_empty ? '0 : head.pc;
        bus.dec_instr = fifo_empty ? NOP_INSTR : head.instr;
        if (bypass_hit) begin
            bus.dec_valid = 1'b1;
            bus.dec_pc    = bus.imem_addr;
            bus.dec_instr = bus.imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: per-cycle vector table plus redirect, latency and reset sequences.
module tb_fetch_buffer;
    import riscv_pkg::*;

    typedef struct {
        logic        ack;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_occ;
        logic        exp_dv;
        logic [31:0] exp_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  occupancy;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wait_cnt = 0;
    int          lat      = 0;
    vec_t        vecs [15];

    fetch_buffer_if bus ();

    fetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h8000_0000;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    function automatic vec_t mk(input logic ack, input logic ready, input logic req,
                                input logic [31:0] addr, input logic [31:0] occ,
                                input logic dv, input logic [31:0] pc);
        vec_t v;
        v.ack = ack; v.ready = ready; v.exp_req = req; v.exp_addr = addr;
        v.exp_occ = occ; v.exp_dv = dv; v.exp_pc = pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic req, input logic [31:0] addr,
                               input logic [31:0] occ, input logic dv, input logic [31:0] pc);
        check({tag, ".imem_req"},  32'(bus.imem_req), 32'(req));
        check({tag, ".imem_addr"}, bus.imem_addr, addr);
        check({tag, ".occupancy"}, 32'(occupancy), occ);
        check({tag, ".dec_valid"}, 32'(bus.dec_valid), 32'(dv));
        check({tag, ".dec_pc"},    bus.dec_pc, dv ? pc : 32'h0);
        check({tag, ".dec_instr"}, bus.dec_instr, dv ? mem_word(pc) : NOP_INSTR);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn           = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.dec_ready  = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Responder that acks `lat` cycles after it first sees a request.
    task automatic mem_drive();
        if (bus.imem_req) begin
            if (wait_cnt == lat) begin
                bus.imem_ack = 1'b1;
                wait_cnt     = 0;
            end else begin
                bus.imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus.imem_ack = 1'b0;
            wait_cnt     = 0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic [31:0] popped [$];
        logic        pending;
        logic [31:0] paddr;

        // Zero-wait streaming, fill to full with ready low, drain, then a short ack gap.
        vecs[0]  = mk(1'b1, 1'b1, 1'b1, 32'h00, 0, 1'b0, 32'h00);
        vecs[1]  = mk(1'b1, 1'b1, 1'b1, 32'h04, 1, 1'b1, 32'h00);
        vecs[2]  = mk(1'b1, 1'b1, 1'b1, 32'h08, 1, 1'b1, 32'h04);
        vecs[3]  = mk(1'b1, 1'b1, 1'b1, 32'h0C, 1, 1'b1, 32'h08);
        vecs[4]  = mk(1'b1, 1'b0, 1'b1, 32'h10, 2, 1'b1, 32'h08);
        vecs[5]  = mk(1'b1, 1'b0, 1'b1, 32'h14, 3, 1'b1, 32'h08);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 32'h14, 4, 1'b1, 32'h08);
        vecs[7]  = mk(1'b1, 1'b0, 1'b0, 32'h14, 4, 1'b1, 32'h08);
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 32'h14, 4, 1'b1, 32'h08);
        vecs[9]  = mk(1'b1, 1'b1, 1'b1, 32'h18, 3, 1'b1, 32'h0C);
        vecs[10] = mk(1'b1, 1'b1, 1'b1, 32'h1C, 3, 1'b1, 32'h10);
        vecs[11] = mk(1'b0, 1'b1, 1'b1, 32'h1C, 2, 1'b1, 32'h14);
        vecs[12] = mk(1'b0, 1'b1, 1'b1, 32'h1C, 1, 1'b1, 32'h18);
        vecs[13] = mk(1'b0, 1'b1, 1'b1, 32'h1C, 0, 1'b0, 32'h00);
        vecs[14] = mk(1'b1, 1'b1, 1'b1, 32'h20, 1, 1'b1, 32'h1C);

        rstn           = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.dec_ready  = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 1'b0, 32'h0, 0, 1'b0, 32'h0);
        rstn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            bus.imem_ack  = vecs[i].ack;
            bus.dec_ready = vecs[i].ready;
            step();
            check_state($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                        vecs[i].exp_occ, vecs[i].exp_dv, vecs[i].exp_pc);
        end

        // Three wait cycles per access: address must hold, each PC delivered exactly once.
        do_reset();
        lat           = 3;
        wait_cnt      = 0;
        bus.dec_ready = 1'b1;
        for (int k = 0; k < 22; k++) begin
            if (bus.dec_valid) begin
                popped.push_back(bus.dec_pc);
                check($sformatf("lat3.instr@%h", bus.dec_pc), bus.dec_instr, mem_word(bus.dec_pc));
            end
            mem_drive();
            pending = bus.imem_req && !bus.imem_ack;
            paddr   = bus.imem_addr;
            step();
            if (pending) begin
                check($sformatf("lat3.addr_stable%0d", k), bus.imem_addr, paddr);
            end
        end
        if (bus.dec_valid) popped.push_back(bus.dec_pc);
        check("lat3.delivered", 32'(popped.size()), 32'd5);
        for (int j = 0; j < popped.size(); j++) begin
            check($sformatf("lat3.order%0d", j), popped[j], 32'(j * 4));
        end
        bus.imem_ack = 1'b0;

        // Redirect while the request for 0x8 waits; its ack arrives two cycles later.
        do_reset();
        bus.dec_ready = 1'b1;
        step();
        check_state("rdA.e1", 1'b1, 32'h0, 0, 1'b0, 32'h0);
        bus.imem_ack = 1'b1;
        step();
        step();
        check_state("rdA.e3", 1'b1, 32'h8, 1, 1'b1, 32'h4);
        bus.imem_ack   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        check_state("rdA.e4", 1'b1, 32'h8, 0, 1'b0, 32'h0);
        redirect_valid = 1'b0;
        step();
        check_state("rdA.e5", 1'b1, 32'h8, 0, 1'b0, 32'h0);
        bus.imem_ack = 1'b1;
        step();
        check_state("rdA.e6", 1'b0, 32'h8, 0, 1'b0, 32'h0);
        bus.imem_ack = 1'b0;
        step();
        check_state("rdA.e7", 1'b1, 32'h100, 0, 1'b0, 32'h0);
        bus.imem_ack = 1'b1;
        step();
        check_state("rdA.e8", 1'b1, 32'h104, 1, 1'b1, 32'h100);

        // Redirect, ack and pop in one cycle; then a redirect near the top of memory to test wrap.
        do_reset();
        bus.dec_ready = 1'b1;
        bus.imem_ack  = 1'b1;
        step();
        step();
        step();
        check_state("rdB.e3", 1'b1, 32'h8, 1, 1'b1, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        check_state("rdB.e4", 1'b0, 32'h8, 0, 1'b0, 32'h0);
        redirect_valid = 1'b0;
        step();
        check_state("rdB.e5", 1'b1, 32'h200, 0, 1'b0, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        check_state("rdB.e6", 1'b0, 32'h200, 0, 1'b0, 32'h0);
        redirect_valid = 1'b0;
        step();
        check_state("rdB.e7", 1'b1, 32'hFFFF_FFFC, 0, 1'b0, 32'h0);
        step();
        check_state("rdB.e8", 1'b1, 32'h0, 1, 1'b1, 32'hFFFF_FFFC);

        // Asynchronous reset in the middle of an outstanding request.
        do_reset();
        bus.imem_ack = 1'b1;
        step();
        step();
        step();
        check_state("arst.pre", 1'b1, 32'h8, 2, 1'b1, 32'h0);
        #1;
        rstn = 1'b0;
        #1;
        check_state("arst.low", 1'b0, 32'h0, 0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step();
        check_state("arst.e1", 1'b1, 32'h0, 0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
